// File: rtl/seq_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mult_pkg: shared FSM state type and width helpers for seq_mult.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_e;

   function automatic int calc_m(input int max_width);
      return $clog2(max_width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_collector_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mult_collector_if: digit stream in, assembled product out.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface seq_mult_collector_if #(
   parameter int P         = 2,
   parameter int MAX_WIDTH = 16
) ();
   import seq_mult_pkg::*;

   localparam int M = calc_m(MAX_WIDTH);

   logic                   start;
   logic [M-1:0]           bitsize;
   logic [P-1:0]           digit;
   logic                   digit_valid;
   logic                   mult_done;
   logic [2*MAX_WIDTH-1:0] res_data;
   logic                   res_valid;
   logic                   res_ready;
   logic                   busy;
   logic                   err;

   modport master (
      output start, bitsize, digit, digit_valid, mult_done, res_ready,
      input  res_data, res_valid, busy, err
   );

   modport slave (
      input  start, bitsize, digit, digit_valid, mult_done, res_ready,
      output res_data, res_valid, busy, err
   );
endinterface
`default_nettype wire

// File: rtl/seq_mult_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mult_collector: gathers LSB-first product digits into a          |
// | sign-extended result offered over a valid/ready handshake.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_mult_collector #(
   parameter int P         = 2,
   parameter int MAX_WIDTH = 16
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   seq_mult_collector_if.slave  bus
);
   import seq_mult_pkg::*;

   localparam int M  = calc_m(MAX_WIDTH);
   localparam int AW = 2 * MAX_WIDTH;
   localparam int CW = $clog2(AW + 1);

   state_e          state_q, state_d;
   logic [M-1:0]    w_q, w_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   asm_q, asm_d;
   logic [AW-1:0]   res_q, res_d;
   logic            err_q, err_d;
   logic            valid_q, valid_d;
   logic [CW-1:0]   n_exp;

   assign n_exp = CW'((2 * int'(w_q)) / P);

   // Replicate bit 2W-1 into every bit above the product width.
   function automatic logic [AW-1:0] sext(input logic [AW-1:0] v, input int w);
      logic [AW-1:0] r;
      r = v;
      if (w > 0) begin
         for (int i = 0; i < AW; i++) begin
            if (i >= 2 * w) r[i] = v[2*w-1];
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      count_d = count_q;
      asm_d   = asm_q;
      res_d   = res_q;
      err_d   = err_q;
      valid_d = valid_q;
      if (bus.start) begin
         state_d = COLLECT;
         w_d     = bus.bitsize;
         count_d = '0;
         asm_d   = '0;
         err_d   = 1'b0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (bus.digit_valid) begin
                  if (count_q < n_exp) begin
                     asm_d[int'(count_q)*P +: P] = bus.digit;
                     count_d = count_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               // The count check sees a digit arriving alongside mult_done.
               if (bus.mult_done) begin
                  if (count_d != n_exp) err_d = 1'b1;
                  res_d   = sext(asm_d, int'(w_q));
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (bus.res_ready) begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= IDLE;
         w_q     <= '0;
         count_q <= '0;
         asm_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         count_q <= count_d;
         asm_q   <= asm_d;
         res_q   <= res_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign bus.res_data  = res_q;
   assign bus.res_valid = valid_q;
   assign bus.err       = err_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire
